// File: rtl/reg_port_arbiter.sv
// rtl/reg_port_arbiter.sv - two-requester round-robin arbiter in front of a register-file port
//
// Purpose: serialises register-file commands from requesters A (index 0) and
// B (index 1). A granted command is issued to the register file for one
// cycle. For reads, the operands are captured the following cycle and then
// returned to the requester with a valid/ready handshake.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_i, rd_i, wr_i              per-requester request level and command flags
//   wsel_i, rsel1_i, rsel2_i       per-requester selects (A in the low slice)
//   wdata_i                        per-requester write data (A in the low slice)
//   gnt_o                          one-cycle grant pulse, coincides with the issue cycle
//   rsp_valid_o, rsp_ready_i       per-requester read-response handshake
//   rdata1_o, rdata2_o             shared read-response data
//   rf_en_o, rf_rd_o, rf_wr_o      register-file strobes
//   rf_sel_i_o, rf_sel_o1_o/o2_o   register-file write / read selects
//   rf_ip_o                        register-file write data
//   rf_op1_i, rf_op2_i             register-file read data, one cycle after rf_rd_o
module reg_port_arbiter #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_i,
   input  logic [1:0]      rd_i,
   input  logic [1:0]      wr_i,
   input  logic [2*AW-1:0] wsel_i,
   input  logic [2*AW-1:0] rsel1_i,
   input  logic [2*AW-1:0] rsel2_i,
   input  logic [2*DW-1:0] wdata_i,
   output logic [1:0]      gnt_o,
   output logic [1:0]      rsp_valid_o,
   input  logic [1:0]      rsp_ready_i,
   output logic [DW-1:0]   rdata1_o,
   output logic [DW-1:0]   rdata2_o,
   output logic            rf_en_o,
   output logic            rf_rd_o,
   output logic            rf_wr_o,
   output logic [AW-1:0]   rf_sel_i_o,
   output logic [AW-1:0]   rf_sel_o1_o,
   output logic [AW-1:0]   rf_sel_o2_o,
   output logic [DW-1:0]   rf_ip_o,
   input  logic [DW-1:0]   rf_op1_i,
   input  logic [DW-1:0]   rf_op2_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;     // requester granted most recently (1 = B)
   logic            owner_q, owner_d;   // requester owning the command in flight
   logic [1:0]      gnt_q, gnt_d;
   logic [1:0]      rsp_valid_q, rsp_valid_d;
   logic            rf_en_q, rf_en_d;
   logic            rf_rd_q, rf_rd_d;
   logic            rf_wr_q, rf_wr_d;
   logic [AW-1:0]   sel_i_q, sel_i_d;
   logic [AW-1:0]   sel_o1_q, sel_o1_d;
   logic [AW-1:0]   sel_o2_q, sel_o2_d;
   logic [DW-1:0]   ip_q, ip_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;
   logic [DW-1:0]   rdata2_q, rdata2_d;
   logic            win;

   // A lone requester wins; with both requesting, the one not granted last wins.
   always_comb begin
      win = 1'b0;
      if (req_i == 2'b01)
         win = 1'b0;
      else if (req_i == 2'b10)
         win = 1'b1;
      else
         win = ~last_q;
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      gnt_d       = 2'b00;
      rsp_valid_d = rsp_valid_q;
      rf_en_d     = 1'b0;
      rf_rd_d     = 1'b0;
      rf_wr_d     = 1'b0;
      sel_i_d     = sel_i_q;
      sel_o1_d    = sel_o1_q;
      sel_o2_d    = sel_o2_q;
      ip_d        = ip_q;
      rdata1_d    = rdata1_q;
      rdata2_d    = rdata2_q;

      case (state_q)
         IDLE: begin
            // Issue outputs are registered here so they appear together
            // with the grant pulse in the ISSUE cycle.
            if (req_i != 2'b00) begin
               state_d  = ISSUE;
               owner_d  = win;
               last_d   = win;
               gnt_d    = win ? 2'b10 : 2'b01;
               rf_en_d  = 1'b1;
               rf_rd_d  = rd_i[win];
               rf_wr_d  = wr_i[win];
               sel_i_d  = win ? wsel_i[2*AW-1:AW]   : wsel_i[AW-1:0];
               sel_o1_d = win ? rsel1_i[2*AW-1:AW]  : rsel1_i[AW-1:0];
               sel_o2_d = win ? rsel2_i[2*AW-1:AW]  : rsel2_i[AW-1:0];
               ip_d     = win ? wdata_i[2*DW-1:DW]  : wdata_i[DW-1:0];
            end
         end
         ISSUE: begin
            state_d = rf_rd_q ? WAIT : IDLE;
         end
         WAIT: begin
            // Register-file read data is valid the cycle after the strobe.
            state_d     = RESP;
            rdata1_d    = rf_op1_i;
            rdata2_d    = rf_op2_i;
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
         end
         RESP: begin
            if (rsp_ready_i[owner_q]) begin
               state_d     = IDLE;
               rsp_valid_d = 2'b00;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;   // B counts as last granted, so A wins first tie
         owner_q     <= 1'b0;
         gnt_q       <= 2'b00;
         rsp_valid_q <= 2'b00;
         rf_en_q     <= 1'b0;
         rf_rd_q     <= 1'b0;
         rf_wr_q     <= 1'b0;
         sel_i_q     <= '0;
         sel_o1_q    <= '0;
         sel_o2_q    <= '0;
         ip_q        <= '0;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rf_en_q     <= rf_en_d;
         rf_rd_q     <= rf_rd_d;
         rf_wr_q     <= rf_wr_d;
         sel_i_q     <= sel_i_d;
         sel_o1_q    <= sel_o1_d;
         sel_o2_q    <= sel_o2_d;
         ip_q        <= ip_d;
         rdata1_q    <= rdata1_d;
         rdata2_q    <= rdata2_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rdata1_o    = rdata1_q;
   assign rdata2_o    = rdata2_q;
   assign rf_en_o     = rf_en_q;
   assign rf_rd_o     = rf_rd_q;
   assign rf_wr_o     = rf_wr_q;
   assign rf_sel_i_o  = sel_i_q;
   assign rf_sel_o1_o = sel_o1_q;
   assign rf_sel_o2_o = sel_o2_q;
   assign rf_ip_o     = ip_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb/tb_reg_port_arbiter.sv - scoreboard bench for reg_port_arbiter
module tb_reg_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      req_i = '0, rd_i = '0, wr_i = '0;
   logic [2*AW-1:0] wsel_i = '0, rsel1_i = '0, rsel2_i = '0;
   logic [2*DW-1:0] wdata_i = '0;
   logic [1:0]      gnt_o, rsp_valid_o;
   logic [1:0]      rsp_ready_i = '0;
   logic [DW-1:0]   rdata1_o, rdata2_o;
   logic            rf_en_o, rf_rd_o, rf_wr_o;
   logic [AW-1:0]   rf_sel_i_o, rf_sel_o1_o, rf_sel_o2_o;
   logic [DW-1:0]   rf_ip_o;
   logic [DW-1:0]   rf_op1_i = '0, rf_op2_i = '0;

   reg_port_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .rd_i(rd_i), .wr_i(wr_i),
      .wsel_i(wsel_i), .rsel1_i(rsel1_i), .rsel2_i(rsel2_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
      .rf_en_o(rf_en_o), .rf_rd_o(rf_rd_o), .rf_wr_o(rf_wr_o),
      .rf_sel_i_o(rf_sel_i_o), .rf_sel_o1_o(rf_sel_o1_o), .rf_sel_o2_o(rf_sel_o2_o),
      .rf_ip_o(rf_ip_o), .rf_op1_i(rf_op1_i), .rf_op2_i(rf_op2_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [AW-1:0] wsel;
      logic [AW-1:0] rsel1;
      logic [AW-1:0] rsel2;
      logic [DW-1:0] wdata;
   } cmd_t;
   typedef struct packed { logic [1:0] gnt; cmd_t c; } gexp_t;
   typedef struct packed { logic [1:0] who; logic [DW-1:0] d1; logic [DW-1:0] d2; } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   int    n_vec = 0;
   int    n_bad = 0;
   bit    ready_hold0 = 1'b0;

   // Register file seen by the DUT: read-before-write on the same strobe.
   logic [DW-1:0] env_rf [16] = '{default: '0};
   always @(posedge clk) begin
      if (rf_en_o && rf_rd_o) begin
         rf_op1_i <= env_rf[rf_sel_o1_o];
         rf_op2_i <= env_rf[rf_sel_o2_o];
      end
      if (rf_en_o && rf_wr_o) env_rf[rf_sel_i_o] <= rf_ip_o;
   end

   // Reference model: register contents and who was granted last.
   logic [DW-1:0] model_rf [16] = '{default: '0};
   bit            model_last_b = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_issue(input bit who, input cmd_t c, input bit with_resp);
      gexp_t g;
      rexp_t r;
      g.gnt = who ? 2'b10 : 2'b01;
      g.c   = c;
      gq.push_back(g);
      if (c.rd && with_resp) begin
         r.who = g.gnt;
         r.d1  = model_rf[c.rsel1];
         r.d2  = model_rf[c.rsel2];
         rq.push_back(r);
      end
      if (c.wr) model_rf[c.wsel] = c.wdata;
      model_last_b = who;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_fields(input bit who, input cmd_t c);
      rd_i[who]             = c.rd;
      wr_i[who]             = c.wr;
      wsel_i[who*AW +: AW]  = c.wsel;
      rsel1_i[who*AW +: AW] = c.rsel1;
      rsel2_i[who*AW +: AW] = c.rsel2;
      wdata_i[who*DW +: DW] = c.wdata;
   endtask

   task automatic wait_idle();
      int budget = 0;
      while ((gq.size() != 0 || rq.size() != 0) && budget < 300) begin
         tick();
         budget++;
      end
      if (gq.size() != 0 || rq.size() != 0) begin
         check("drain_timeout", 64'(gq.size() + rq.size()), 64'd0);
         gq.delete();
         rq.delete();
      end
      tick();
   endtask

   task automatic do_round(input bit a_en, input bit b_en, input cmd_t ca, input cmd_t cb);
      logic [1:0] pending;
      int         budget = 0;
      if (a_en && b_en) begin
         if (model_last_b) begin model_issue(1'b0, ca, 1'b1); model_issue(1'b1, cb, 1'b1); end
         else              begin model_issue(1'b1, cb, 1'b1); model_issue(1'b0, ca, 1'b1); end
      end else if (a_en) model_issue(1'b0, ca, 1'b1);
      else if (b_en)     model_issue(1'b1, cb, 1'b1);
      set_fields(1'b0, ca);
      set_fields(1'b1, cb);
      pending = {b_en, a_en};
      req_i   = pending;
      while (pending != 2'b00 && budget < 300) begin
         tick();
         if (budget == 0) check("req_to_gnt_latency", 64'(gnt_o != 2'b00), 64'd1);
         budget++;
         pending = pending & ~gnt_o;
         req_i   = pending;
      end
      if (pending != 2'b00) begin
         check("grant_timeout", 64'(pending), 64'd0);
         req_i = 2'b00;
      end
      wait_idle();
   endtask

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.rd    = 1'($urandom_range(0, 1));
      c.wr    = 1'($urandom_range(0, 1));
      c.wsel  = AW'($urandom_range(0, 15));
      c.rsel1 = AW'($urandom_range(0, 15));
      c.rsel2 = AW'($urandom_range(0, 15));
      c.wdata = $urandom;
      return c;
   endfunction

   function automatic cmd_t mk(input bit rd, input bit wr, input int ws, input int r1,
                               input int r2, input logic [DW-1:0] d);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.wsel = AW'(ws); c.rsel1 = AW'(r1); c.rsel2 = AW'(r2); c.wdata = d;
      return c;
   endfunction

   // Monitor: drives the response ready, then checks what the DUT presents.
   int            cyc = 0;
   int            rsp_due = -1;
   bit            stall = 1'b0;
   bit            prev_any = 1'b0;
   logic [1:0]    pv;
   logic [DW-1:0] pd1, pd2;
   cmd_t          lastc = '0;
   always @(negedge clk) begin
      gexp_t g;
      rexp_t r;
      cyc++;
      rsp_ready_i = ready_hold0 ? 2'b00 : 2'($urandom_range(0, 3));
      if (rst) begin
         stall    = 1'b0;
         prev_any = 1'b0;
         lastc    = '0;
      end else begin
         if (gnt_o != 2'b00) begin
            check("gnt_during_resp", 64'(rsp_valid_o), 64'd0);
            if (gq.size() == 0) begin
               check("gnt_unexpected", 64'(gnt_o), 64'd0);
            end else begin
               g = gq.pop_front();
               check("gnt", 64'(gnt_o), 64'(g.gnt));
               check("rf_en", 64'(rf_en_o), 64'd1);
               check("rf_rd", 64'(rf_rd_o), 64'(g.c.rd));
               check("rf_wr", 64'(rf_wr_o), 64'(g.c.wr));
               check("rf_sels", 64'({rf_sel_i_o, rf_sel_o1_o, rf_sel_o2_o}),
                     64'({g.c.wsel, g.c.rsel1, g.c.rsel2}));
               check("rf_ip", 64'(rf_ip_o), 64'(g.c.wdata));
               lastc = g.c;
               if (g.c.rd) rsp_due = cyc + 2;
            end
         end else begin
            check("idle_strobes", 64'({rf_en_o, rf_rd_o, rf_wr_o}), 64'd0);
            check("held_sels_ip", 64'({rf_sel_i_o, rf_sel_o1_o, rf_sel_o2_o, rf_ip_o}),
                  64'({lastc.wsel, lastc.rsel1, lastc.rsel2, lastc.wdata}));
         end
         if (stall) begin
            check("stall_valid", 64'(rsp_valid_o), 64'(pv));
            check("stall_rdata1", 64'(rdata1_o), 64'(pd1));
            check("stall_rdata2", 64'(rdata2_o), 64'(pd2));
         end
         if (rsp_valid_o != 2'b00 && !prev_any)
            check("gnt_to_rsp_latency", 64'(cyc), 64'(rsp_due));
         prev_any = (rsp_valid_o != 2'b00);
         stall    = 1'b0;
         if (rsp_valid_o != 2'b00) begin
            if ((rsp_valid_o & rsp_ready_i) != 2'b00) begin
               if (rq.size() == 0) begin
                  check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
               end else begin
                  r = rq.pop_front();
                  check("rsp_valid", 64'(rsp_valid_o), 64'(r.who));
                  check("rdata1", 64'(rdata1_o), 64'(r.d1));
                  check("rdata2", 64'(rdata2_o), 64'(r.d2));
               end
            end else begin
               stall = 1'b1;
               pv    = rsp_valid_o;
               pd1   = rdata1_o;
               pd2   = rdata2_o;
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"}, 64'(gnt_o), 64'd0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
      check({tag, "_strobes"}, 64'({rf_en_o, rf_rd_o, rf_wr_o}), 64'd0);
      check({tag, "_sels"}, 64'({rf_sel_i_o, rf_sel_o1_o, rf_sel_o2_o}), 64'd0);
      check({tag, "_ip"}, 64'(rf_ip_o), 64'd0);
      check({tag, "_rdata1"}, 64'(rdata1_o), 64'd0);
      check({tag, "_rdata2"}, 64'(rdata2_o), 64'd0);
   endtask

   initial begin
      cmd_t nop, c;
      int   pat;
      nop = '0;
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Single write, then read back from B.
      do_round(1'b1, 1'b0, mk(0, 1, 3, 0, 0, 32'hDEADBEEF), nop);
      do_round(1'b0, 1'b1, nop, mk(1, 0, 0, 3, 0, 32'h0));
      // Continuous simultaneous requests alternate.
      for (int i = 0; i < 3; i++)
         do_round(1'b1, 1'b1, mk(0, 1, i, 0, 0, 32'h100 + i), mk(0, 1, i + 8, 0, 0, 32'h200 + i));
      // Read+write of the same register returns the old value.
      do_round(1'b1, 1'b0, mk(0, 1, 5, 0, 0, 32'd1), nop);
      do_round(1'b1, 1'b0, mk(1, 1, 5, 5, 3, 32'd2), nop);
      do_round(1'b0, 1'b1, nop, mk(1, 0, 0, 5, 5, 32'h0));
      // No-op command.
      do_round(1'b1, 1'b0, nop, nop);
      // Backpressure with the other requester waiting.
      ready_hold0 = 1'b1;
      fork
         begin repeat (9) tick(); ready_hold0 = 1'b0; end
         do_round(1'b1, 1'b1, mk(1, 0, 0, 3, 8, 32'h0), mk(1, 0, 0, 5, 9, 32'h0));
      join

      // Reset while waiting for read data.
      c = mk(1, 0, 0, 3, 5, 32'h0);
      model_issue(1'b0, c, 1'b0);
      set_fields(1'b0, c);
      req_i = 2'b01;
      tick();
      check("rst_test_gnt", 64'(gnt_o), 64'd1);
      req_i = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("midop_reset");
      rst = 1'b0;
      model_last_b = 1'b1;
      tick();
      do_round(1'b1, 1'b1, mk(0, 1, 12, 0, 0, 32'hA), mk(0, 1, 13, 0, 0, 32'hB));

      // Randomised rounds.
      for (int i = 0; i < 60; i++) begin
         pat = $urandom_range(1, 3);
         do_round(pat[0], pat[1], rand_cmd(), rand_cmd());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
